// File: rtl/rs_age_ordered.sv
// rs_age_ordered: parametrised reservation station with oldest-first issue.
//
// Sits between dispatch/rename and the FU input FIFOs. Up to DISP_W
// instructions are written per cycle into the lowest-index free entries.
// Sources wake up from the CDB, both for resident entries and for
// instructions dispatching in the same cycle. Up to ISS_W ready entries
// leave per cycle, oldest first, with at most one per FU class. Relative
// age is kept in an age matrix rather than derived from entry indices.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   squash           flush every entry at the next edge
//   disp_*           DISP_W dispatch lanes (lane 0 is the oldest instruction)
//   disp_stall       lane k cannot be accepted this cycle
//   cdb_valid/tag    CDB_W completing-tag broadcast lanes
//   fu_ready         per FU class: can take one instruction this cycle
//   issue_*          ISS_W issue lanes (lane 0 carries the oldest selection)
//   free_count       number of invalid entries (registered state)
module rs_age_ordered #(
  parameter int DEPTH  = 16,
  parameter int DISP_W = 3,
  parameter int ISS_W  = 3,
  parameter int CDB_W  = 3,
  parameter int TAG_W  = 6,
  parameter int PAY_W  = 96,
  parameter int NFU    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash,
  input  logic [DISP_W-1:0]             disp_valid,
  input  logic [DISP_W*TAG_W-1:0]       disp_src1_tag,
  input  logic [DISP_W-1:0]             disp_src1_rdy,
  input  logic [DISP_W*TAG_W-1:0]       disp_src2_tag,
  input  logic [DISP_W-1:0]             disp_src2_rdy,
  input  logic [DISP_W*$clog2(NFU)-1:0] disp_fu,
  input  logic [DISP_W*PAY_W-1:0]       disp_payload,
  output logic [DISP_W-1:0]             disp_stall,
  input  logic [CDB_W-1:0]              cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]        cdb_tag,
  input  logic [NFU-1:0]                fu_ready,
  output logic [ISS_W-1:0]              issue_valid,
  output logic [ISS_W*TAG_W-1:0]        issue_src1_tag,
  output logic [ISS_W*TAG_W-1:0]        issue_src2_tag,
  output logic [ISS_W*$clog2(NFU)-1:0]  issue_fu,
  output logic [ISS_W*PAY_W-1:0]        issue_payload,
  output logic [$clog2(DEPTH):0]        free_count
);

  localparam int FU_W   = $clog2(NFU);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int LANE_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

  // True when any valid CDB lane broadcasts the given tag.
  function automatic logic cdb_hit(input logic [TAG_W-1:0]       tag,
                                   input logic [CDB_W-1:0]       valid,
                                   input logic [CDB_W*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < CDB_W; j++) begin
      hit = hit | (valid[j] & (tags[j*TAG_W +: TAG_W] == tag));
    end
    return hit;
  endfunction

  // Entry state
  logic [DEPTH-1:0] valid_r;
  logic [TAG_W-1:0] src1_tag_r [DEPTH];
  logic [TAG_W-1:0] src2_tag_r [DEPTH];
  logic [DEPTH-1:0] src1_rdy_r;
  logic [DEPTH-1:0] src2_rdy_r;
  logic [FU_W-1:0]  fu_r       [DEPTH];
  logic [PAY_W-1:0] payload_r  [DEPTH];
  // older_r[i][j] = 1: entry i is older than entry j
  logic [DEPTH-1:0] older_r    [DEPTH];
  logic [CNT_W-1:0] free_count_r;

  // Combinational working signals
  logic             active_s;
  logic [DEPTH-1:0] src1_rdy_s, src2_rdy_s, ready_s;
  logic [DEPTH-1:0] cand_s, win_s, issued_s;
  logic             has_older_s;
  logic [NFU-1:0]   used_s;
  logic [ISS_W-1:0] iss_v_s;
  logic [IDX_W-1:0] iss_idx_s  [ISS_W];

  logic [DISP_W-1:0] disp_stall_s, accept_s;
  logic [TAG_W-1:0]  d_tag1_s   [DISP_W];
  logic [TAG_W-1:0]  d_tag2_s   [DISP_W];
  logic [DISP_W-1:0] d_rdy1_s, d_rdy2_s;
  logic [FU_W-1:0]   d_fu_s     [DISP_W];
  logic [PAY_W-1:0]  d_pay_s    [DISP_W];
  logic [CNT_W-1:0]  running_s;
  logic [CNT_W-1:0]  free_rank_s [DEPTH];
  logic [DEPTH-1:0]  alloc_s;
  logic [LANE_W-1:0] alloc_lane_s [DEPTH];

  logic [DEPTH-1:0]  valid_n_s;
  logic [DEPTH-1:0]  older_n_s [DEPTH];
  logic [CNT_W-1:0]  free_next_s;

  // Reset and squash both suppress issue and dispatch writes.
  assign active_s = ~reset & ~squash;

  // Bypassed source readiness of resident entries for this cycle's selection.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src1_rdy_s[i] = src1_rdy_r[i] | cdb_hit(src1_tag_r[i], cdb_valid, cdb_tag);
      src2_rdy_s[i] = src2_rdy_r[i] | cdb_hit(src2_tag_r[i], cdb_valid, cdb_tag);
      ready_s[i]    = valid_r[i] & src1_rdy_s[i] & src2_rdy_s[i] & fu_ready[fu_r[i]];
    end
  end

  // Per-lane oldest-first selection with one grant per FU class.
  always_comb begin
    issued_s    = '0;
    used_s      = '0;
    cand_s      = '0;
    win_s       = '0;
    has_older_s = 1'b0;
    iss_v_s     = '0;
    for (int l = 0; l < ISS_W; l++) begin
      iss_idx_s[l] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        cand_s[i] = active_s & ready_s[i] & ~issued_s[i] & ~used_s[fu_r[i]];
      end
      // A winner is a candidate that no other candidate is older than.
      for (int i = 0; i < DEPTH; i++) begin
        has_older_s = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
          has_older_s = has_older_s | (cand_s[j] & older_r[j][i]);
        end
        win_s[i] = cand_s[i] & ~has_older_s;
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
        iss_idx_s[l] = win_s[i] ? IDX_W'(i) : iss_idx_s[l];
        iss_v_s[l]   = iss_v_s[l] | win_s[i];
      end
      issued_s[iss_idx_s[l]]     = issued_s[iss_idx_s[l]] | iss_v_s[l];
      used_s[fu_r[iss_idx_s[l]]] = used_s[fu_r[iss_idx_s[l]]] | iss_v_s[l];
    end
  end

  // Issue lane outputs; unfilled lanes drive zeros.
  always_comb begin
    issue_valid    = iss_v_s;
    issue_src1_tag = '0;
    issue_src2_tag = '0;
    issue_fu       = '0;
    issue_payload  = '0;
    for (int l = 0; l < ISS_W; l++) begin
      issue_src1_tag[l*TAG_W +: TAG_W] = iss_v_s[l] ? src1_tag_r[iss_idx_s[l]] : {TAG_W{1'b0}};
      issue_src2_tag[l*TAG_W +: TAG_W] = iss_v_s[l] ? src2_tag_r[iss_idx_s[l]] : {TAG_W{1'b0}};
      issue_fu[l*FU_W +: FU_W]         = iss_v_s[l] ? fu_r[iss_idx_s[l]]       : {FU_W{1'b0}};
      issue_payload[l*PAY_W +: PAY_W]  = iss_v_s[l] ? payload_r[iss_idx_s[l]]  : {PAY_W{1'b0}};
    end
  end

  // Stall from registered free count only; slots freed by issue wait a cycle.
  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      disp_stall_s[k] = (free_count_r < CNT_W'(k + 1));
    end
  end

  assign disp_stall = disp_stall_s;
  assign free_count = free_count_r;

  // Unpack dispatch lanes, applying same-cycle CDB wakeup to their sources.
  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      d_tag1_s[k] = disp_src1_tag[k*TAG_W +: TAG_W];
      d_tag2_s[k] = disp_src2_tag[k*TAG_W +: TAG_W];
      d_rdy1_s[k] = disp_src1_rdy[k] | cdb_hit(d_tag1_s[k], cdb_valid, cdb_tag);
      d_rdy2_s[k] = disp_src2_rdy[k] | cdb_hit(d_tag2_s[k], cdb_valid, cdb_tag);
      d_fu_s[k]   = disp_fu[k*FU_W +: FU_W];
      d_pay_s[k]  = disp_payload[k*PAY_W +: PAY_W];
      accept_s[k] = disp_valid[k] & ~disp_stall_s[k] & active_s;
    end
  end

  // Accepted lane k takes the free entry whose free-rank equals k.
  always_comb begin
    running_s = '0;
    alloc_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_rank_s[i]  = running_s;
      running_s       = running_s + {{(CNT_W-1){1'b0}}, ~valid_r[i]};
      alloc_lane_s[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < DISP_W; k++) begin
        if (accept_s[k] && !valid_r[i] && (free_rank_s[i] == CNT_W'(k))) begin
          alloc_s[i]      = 1'b1;
          alloc_lane_s[i] = LANE_W'(k);
        end else begin
          alloc_lane_s[i] = alloc_lane_s[i];
        end
      end
    end
  end

  // Next valid bits, free count and age matrix.
  always_comb begin
    free_next_s = CNT_W'(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      valid_n_s[i] = (valid_r[i] & ~issued_s[i]) | alloc_s[i];
      free_next_s  = free_next_s - {{(CNT_W-1){1'b0}}, valid_n_s[i]};
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc_s[j]) begin
          // New entry j is younger than all survivors and lower-lane newcomers.
          older_n_s[i][j] = (valid_r[i] & ~issued_s[i]) |
                            (alloc_s[i] & (alloc_lane_s[i] < alloc_lane_s[j]));
        end else if (alloc_s[i]) begin
          older_n_s[i][j] = 1'b0;
        end else begin
          older_n_s[i][j] = older_r[i][j];
        end
      end
    end
  end

  // Entry state, age matrix and free count registers.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      valid_r      <= '0;
      free_count_r <= CNT_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        older_r[i] <= '0;
      end
    end else begin
      valid_r      <= valid_n_s;
      free_count_r <= free_next_s;
      for (int i = 0; i < DEPTH; i++) begin
        older_r[i] <= older_n_s[i];
        if (alloc_s[i]) begin
          src1_tag_r[i] <= d_tag1_s[alloc_lane_s[i]];
          src2_tag_r[i] <= d_tag2_s[alloc_lane_s[i]];
          src1_rdy_r[i] <= d_rdy1_s[alloc_lane_s[i]];
          src2_rdy_r[i] <= d_rdy2_s[alloc_lane_s[i]];
          fu_r[i]       <= d_fu_s[alloc_lane_s[i]];
          payload_r[i]  <= d_pay_s[alloc_lane_s[i]];
        end else begin
          src1_rdy_r[i] <= src1_rdy_s[i];
          src2_rdy_r[i] <= src2_rdy_s[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_age_ordered.sv
// Testbench for rs_age_ordered: directed scenarios plus random traffic,
// checked against an age-ordered list model with an expected-issue queue.
module tb_rs_age_ordered;
  localparam int DEPTH = 16, DISP_W = 3, ISS_W = 3, CDB_W = 3;
  localparam int TAG_W = 6, PAY_W = 96, NFU = 4;

  logic                   clock = 1'b0;
  logic                   reset, squash;
  logic [DISP_W-1:0]      disp_valid, disp_src1_rdy, disp_src2_rdy, disp_stall;
  logic [DISP_W*TAG_W-1:0] disp_src1_tag, disp_src2_tag;
  logic [DISP_W*2-1:0]    disp_fu;
  logic [DISP_W*PAY_W-1:0] disp_payload;
  logic [CDB_W-1:0]       cdb_valid;
  logic [CDB_W*TAG_W-1:0] cdb_tag;
  logic [NFU-1:0]         fu_ready;
  logic [ISS_W-1:0]       issue_valid;
  logic [ISS_W*TAG_W-1:0] issue_src1_tag, issue_src2_tag;
  logic [ISS_W*2-1:0]     issue_fu;
  logic [ISS_W*PAY_W-1:0] issue_payload;
  logic [4:0]             free_count;

  always #5 clock = ~clock;

  rs_age_ordered #(.DEPTH(DEPTH), .DISP_W(DISP_W), .ISS_W(ISS_W), .CDB_W(CDB_W),
                   .TAG_W(TAG_W), .PAY_W(PAY_W), .NFU(NFU)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .disp_valid(disp_valid), .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy), .disp_fu(disp_fu),
    .disp_payload(disp_payload), .disp_stall(disp_stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_src1_tag(issue_src1_tag),
    .issue_src2_tag(issue_src2_tag), .issue_fu(issue_fu),
    .issue_payload(issue_payload), .free_count(free_count));

  // Model entry: kept in a queue ordered oldest first.
  typedef struct {
    int         idx;
    logic [5:0] t1;
    logic [5:0] t2;
    bit         r1;
    bit         r2;
    int         fu;
    logic [95:0] pay;
  } ent_t;

  typedef struct {
    int         cyc;
    int         lane;
    logic [5:0] t1;
    logic [5:0] t2;
    int         fu;
    logic [95:0] pay;
  } exp_t;

  ent_t ents[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  exp_t me;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  function automatic bit hit(input logic [5:0] t);
    bit h;
    h = 1'b0;
    for (int j = 0; j < CDB_W; j++) begin
      if (cdb_valid[j] && cdb_tag[j*TAG_W +: TAG_W] == t) h = 1'b1;
    end
    return h;
  endfunction

  task automatic clear_in();
    squash = 1'b0; disp_valid = '0; disp_src1_tag = '0; disp_src2_tag = '0;
    disp_src1_rdy = '0; disp_src2_rdy = '0; disp_fu = '0; disp_payload = '0;
    cdb_valid = '0; cdb_tag = '0; fu_ready = 4'b1111;
  endtask

  task automatic set_lane(input int k, input int t1, input bit r1, input int t2, input bit r2, input int fu);
    disp_valid[k] = 1'b1;
    disp_src1_tag[k*TAG_W +: TAG_W] = 6'(t1);
    disp_src1_rdy[k] = r1;
    disp_src2_tag[k*TAG_W +: TAG_W] = 6'(t2);
    disp_src2_rdy[k] = r2;
    disp_fu[k*2 +: 2] = 2'(fu);
    disp_payload[k*PAY_W +: PAY_W] = {$urandom(), 32'(cyc), 32'(k)};
  endtask

  task automatic set_cdb(input int j, input int t);
    cdb_valid[j] = 1'b1;
    cdb_tag[j*TAG_W +: TAG_W] = 6'(t);
  endtask

  // Check status, model this cycle with the driven inputs, then advance.
  task automatic do_cycle();
    int   nfree;
    bit   st [DISP_W];
    bit   occ [DEPTH];
    int   fl[$];
    bit   taken [DEPTH];
    bit   used [NFU];
    bit   found;
    ent_t e;
    ent_t keep[$];
    ent_t nw[$];
    nfree = DEPTH - ents.size();
    for (int k = 0; k < DISP_W; k++) st[k] = (nfree < k + 1);
    chk("free_count", 128'(free_count), 128'(nfree));
    chk("disp_stall", 128'(disp_stall), 128'({st[2], st[1], st[0]}));
    if (reset || squash) begin
      ents.delete();
    end else begin
      for (int i = 0; i < DEPTH; i++) begin occ[i] = 1'b0; taken[i] = 1'b0; end
      for (int c = 0; c < NFU; c++) used[c] = 1'b0;
      foreach (ents[p]) occ[ents[p].idx] = 1'b1;
      for (int i = 0; i < DEPTH; i++) if (!occ[i]) fl.push_back(i);
      for (int l = 0; l < ISS_W; l++) begin
        found = 1'b0;
        for (int p = 0; p < ents.size(); p++) begin
          e = ents[p];
          if (!found && !taken[p] && (e.r1 || hit(e.t1)) && (e.r2 || hit(e.t2)) &&
              fu_ready[e.fu] && !used[e.fu]) begin
            found = 1'b1; taken[p] = 1'b1; used[e.fu] = 1'b1;
            exp_q.push_back('{cyc, l, e.t1, e.t2, e.fu, e.pay});
          end
        end
      end
      for (int k = 0; k < DISP_W; k++) begin
        if (disp_valid[k] && !st[k]) begin
          e.idx = fl[k];
          e.t1  = disp_src1_tag[k*TAG_W +: TAG_W];
          e.t2  = disp_src2_tag[k*TAG_W +: TAG_W];
          e.r1  = disp_src1_rdy[k] || hit(e.t1);
          e.r2  = disp_src2_rdy[k] || hit(e.t2);
          e.fu  = int'(disp_fu[k*2 +: 2]);
          e.pay = disp_payload[k*PAY_W +: PAY_W];
          nw.push_back(e);
        end
      end
      for (int p = 0; p < ents.size(); p++) begin
        if (!taken[p]) begin
          e = ents[p];
          e.r1 = e.r1 || hit(e.t1);
          e.r2 = e.r2 || hit(e.t2);
          keep.push_back(e);
        end
      end
      ents = keep;
      foreach (nw[p]) ents.push_back(nw[p]);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Broadcast every tag value repeatedly so all waiting entries drain.
  task automatic drain(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      clear_in();
      for (int j = 0; j < CDB_W; j++) set_cdb(j, (r * 3 + j) % 64);
      do_cycle();
    end
  endtask

  // Monitor: compares every presented issue lane against the expected queue.
  always @(negedge clock) begin
    if (mon_on) begin
      for (int l = 0; l < ISS_W; l++) begin
        if (issue_valid[l]) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_issue cycle=%0d lane=%0d got=1 want=0", cyc, l);
          end else begin
            me = exp_q.pop_front();
            chk("issue_cycle", 128'(cyc), 128'(me.cyc));
            chk("issue_lane", 128'(l), 128'(me.lane));
            chk("issue_src1_tag", 128'(issue_src1_tag[l*TAG_W +: TAG_W]), 128'(me.t1));
            chk("issue_src2_tag", 128'(issue_src2_tag[l*TAG_W +: TAG_W]), 128'(me.t2));
            chk("issue_fu", 128'(issue_fu[l*2 +: 2]), 128'(me.fu));
            chk("issue_payload", 128'(issue_payload[l*PAY_W +: PAY_W]), 128'(me.pay));
          end
        end else begin
          chk("idle_lane_zero", 128'({issue_src1_tag[l*TAG_W +: TAG_W], issue_src2_tag[l*TAG_W +: TAG_W],
                                      issue_fu[l*2 +: 2], issue_payload[l*PAY_W +: PAY_W]}), 128'(0));
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].lane == l) begin
            chk("issue_valid", 128'(0), 128'(1));
            me = exp_q.pop_front();
          end
        end
      end
    end
  end

  initial begin
    clear_in();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_free_count", 128'(free_count), 128'(16));
    chk("reset_disp_stall", 128'(disp_stall), 128'(0));
    chk("reset_issue_valid", 128'(issue_valid), 128'(0));
    mon_on = 1'b1;

    // Three ready ops, distinct classes: allocate 0..2, issue together next cycle.
    clear_in();
    set_lane(0, 1, 1, 2, 1, 0); set_lane(1, 3, 1, 4, 1, 2); set_lane(2, 5, 1, 6, 1, 3);
    do_cycle();
    chk("t1_free_after_disp", 128'(free_count), 128'(13));
    clear_in();
    do_cycle();
    chk("t1_free_after_issue", 128'(free_count), 128'(16));

    // Entry 5 gets an ALU op before entry 2 does; entry 5 must issue first.
    clear_in();
    for (int k = 0; k < 3; k++) set_lane(k, 48 + k, 0, 0, 1, 3);
    do_cycle();
    clear_in();
    for (int k = 0; k < 3; k++) set_lane(k, 51 + k, 0, 0, 1, 3);
    do_cycle();
    clear_in(); set_cdb(0, 53);
    do_cycle();
    clear_in(); fu_ready = 4'b1110; set_lane(0, 7, 1, 8, 1, 0); set_cdb(0, 50);
    do_cycle();
    clear_in(); fu_ready = 4'b1110; set_lane(0, 9, 1, 10, 1, 0);
    do_cycle();
    clear_in();
    do_cycle();
    do_cycle();
    drain(24);

    // Same-cycle wakeup of a resident entry and of a dispatching entry.
    clear_in(); set_lane(0, 26, 0, 5, 1, 0);
    do_cycle();
    clear_in(); set_cdb(0, 26); set_cdb(1, 27); set_lane(0, 27, 0, 6, 1, 1);
    do_cycle();
    clear_in();
    do_cycle();
    chk("t3_free_after_wakeups", 128'(free_count), 128'(16));

    // Fill to 15, then offer three lanes: only lane 0 fits.
    for (int c = 0; c < 5; c++) begin
      clear_in();
      for (int k = 0; k < 3; k++) set_lane(k, 63, 0, 63, 0, k);
      do_cycle();
    end
    chk("t4_stall_at_15", 128'(disp_stall), 128'(3'b110));
    clear_in();
    for (int k = 0; k < 3; k++) set_lane(k, 63, 0, 63, 0, 1);
    do_cycle();
    chk("t4_free_full", 128'(free_count), 128'(0));
    chk("t4_stall_full", 128'(disp_stall), 128'(3'b111));
    drain(40);

    // Ten ready entries held back, then squash while dispatching.
    for (int c = 0; c < 4; c++) begin
      clear_in(); fu_ready = 4'b0000;
      for (int k = 0; k < ((c == 3) ? 1 : 3); k++) set_lane(k, 11, 1, 12, 1, k);
      do_cycle();
    end
    clear_in(); squash = 1'b1;
    for (int k = 0; k < 3; k++) set_lane(k, 13, 1, 14, 1, k);
    do_cycle();
    chk("t5_free_after_squash", 128'(free_count), 128'(16));
    clear_in();
    do_cycle();

    // Oldest is an LS op with its FU busy: the younger ALU op goes first.
    clear_in(); fu_ready = 4'b1101;
    set_lane(0, 15, 1, 16, 1, 1); set_lane(1, 17, 1, 18, 1, 0);
    do_cycle();
    clear_in(); fu_ready = 4'b1101;
    do_cycle();
    clear_in(); fu_ready = 4'b1101;
    do_cycle();
    clear_in();
    do_cycle();
    chk("t6_free_after_ls", 128'(free_count), 128'(16));

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      int n;
      clear_in();
      squash = ($urandom_range(0, 49) == 0);
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++)
        set_lane(k, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      for (int j = 0; j < CDB_W; j++)
        if ($urandom_range(0, 1) == 1) set_cdb(j, $urandom_range(0, 15));
      for (int f = 0; f < NFU; f++) fu_ready[f] = ($urandom_range(0, 3) != 0);
      do_cycle();
    end

    drain(40);
    clear_in();
    repeat (3) do_cycle();
    chk("expected_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
